serial_frame_gen: RTL and testbench
===================================

// Module: serial_frame_gen
// PURPOSE
//  Parametrised serial frame transmitter for bench stimulus and on-board loopback.
//  Replaces hand-written per-bit delay loops for UART and PS/2 device traffic.
//  Runtime-selectable UART or PS/2 device mode, programmable bit period, parity and inter-frame gap.
//  Input is a byte FIFO, so a file reader or a CPU can stream bytes without per-bit timing.
// PARAMETERS
//  DIV_W       16  width of bit_div and gap counters
//  FIFO_DEPTH  16  byte FIFO entries; power of 2, >= 2
//  LVL_W        5  width of fifo_level; must equal log2(FIFO_DEPTH)+1
// PORTS
//  clk         in   1      system clock
//  reset       in   1      synchronous, active-high
//  mode        in   1      0 = UART, 1 = PS/2 device
//  bit_div     in   DIV_W  UART: cycles per bit; PS/2: cycles per clock half-period; 0 is treated as 1
//  parity_sel  in   2      UART only: 0 none, 1 odd, 2 even, 3 none; PS/2 always uses odd
//  gap         in   DIV_W  idle cycles inserted after each stop bit, before the next start
//  in_data     in   8      byte to send
//  in_valid    in   1      push request; accepted when in_valid && in_ready
//  in_ready    out  1      FIFO not full
//  tx_line     out  1      UART TXD / PS/2 data line
//  ps2_clk     out  1      PS/2 clock line; constant 1 in UART mode
//  busy        out  1      a frame, including its gap, is in progress
//  fifo_level  out  LVL_W  bytes currently queued, 0..FIFO_DEPTH
// BEHAVIOUR
//  Reset values
//  - tx_line=1, ps2_clk=1, busy=0, in_ready=1, fifo_level=0.
//  - FIFO is flushed and the FSM returns to IDLE.
//  - A reset mid-frame truncates the frame; both lines are 1 on the cycle after reset.
//  FIFO
//  - Push on in_valid && in_ready; pop when IDLE and not empty.
//  - Push and pop in the same cycle leave the level unchanged.
//  - When full, in_ready=0 and in_valid is ignored, even if a pop occurs in that cycle.
//  - Pointers wrap modulo FIFO_DEPTH.
//  Configuration latch
//  - mode, bit_div, parity_sel and gap are latched at the pop.
//  - Changes to these inputs mid-frame have no effect until the next frame.
//  Latency
//  - A byte pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1.
//  - The start bit is driven (tx_line=0) from edge N+2.
//  FSM states: IDLE -> START -> DATA(8, LSB first) -> PAR (skipped if no parity) -> STOP -> GAP -> IDLE.
//  - GAP is skipped when gap=0.
//  - busy=1 in every state except IDLE.
//  UART timing
//  - Each bit holds tx_line for bit_div cycles; ps2_clk stays 1.
//  - Frame length is (10 + parity) * bit_div cycles.
//  PS/2 timing
//  - For each of 11 bits (start 0, 8 data, odd parity, stop 1), tx_line changes on the same edge that ps2_clk falls.
//  - ps2_clk is held low for bit_div cycles, then high for bit_div cycles.
//  - After the stop bit's high half-period, ps2_clk=1 and tx_line=1.
//  Parity
//  - odd = ~^data; even = ^data.
//  Counters
//  - The bit timer is DIV_W wide and reloads with max(bit_div,1)-1; there is no wrap inside a bit.
//  - The gap counter counts gap cycles exactly.
//  Back-to-back frames
//  - With gap=0 and the FIFO not empty, the next start bit begins on the cycle after STOP ends plus one IDLE/pop cycle.
//  - That cycle holds tx_line=1.
// TESTING
//  - UART, bit_div=8, parity none, push 0x41: tx_line low 8 cycles, then bits 1,0,0,0,0,0,1,0 (8 cycles each), high 8; busy for 80 cycles.
//  - PS/2, bit_div=4, push 0x41: 11 ps2_clk falls 8 cycles apart; tx_line sampled at the falls = 0,1,0,0,0,0,0,1,0,1,1.
//  - UART even parity, push 0x07: parity bit=1, frame 88 cycles at bit_div=8; odd parity, 0x07 gives parity bit 0.
//  - Push 17 bytes back-to-back with the FSM stalled at bit_div=1000: fifo_level reaches 16, in_ready=0, 17th byte dropped; the 16 sent bytes match in order.
//  - gap=20, two bytes queued: tx_line stays 1 for 20 cycles + 1 pop cycle between stop and next start.
//  - Reset asserted mid-DATA in PS/2 mode: next cycle tx_line=1, ps2_clk=1, busy=0, fifo_level=0; a fresh push sends a complete frame.

Source files
------------

// File: rtl/serial_frame_gen.sv
// rtl/serial_frame_gen.sv - UART / PS/2 device serial frame transmitter fed from a byte FIFO
module serial_frame_gen #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int LVL_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mode,
    input  logic [DIV_W-1:0] bit_div,
    input  logic [1:0]       parity_sel,
    input  logic [DIV_W-1:0] gap,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             tx_line,
    output logic             ps2_clk,
    output logic             busy,
    output logic [LVL_W-1:0] fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_GAP} state_t;

    state_t           state;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             armed;
    logic [7:0]       data_q;
    logic             mode_q;
    logic             par_en_q;
    logic             par_bit_q;
    logic [DIV_W-1:0] div_m1_q;
    logic [DIV_W-1:0] gap_q;
    logic [DIV_W-1:0] timer;
    logic             half;
    logic [2:0]       bit_idx;

    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       bit_end;
    logic       frame_end;
    logic [7:0] head;
    logic       par_odd;

    assign full     = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign empty    = (fifo_level == '0);
    assign in_ready = !full;
    assign push     = in_valid && !full;
    assign head     = mem[rd_ptr];
    assign par_odd  = mode || (parity_sel == 2'd1);

    // A PS/2 bit only ends after its high half-period; a UART bit ends on timer expiry.
    assign bit_end   = (timer == '0) && (!mode_q || half);
    assign frame_end = (state == S_STOP && bit_end && gap_q == '0) ||
                       (state == S_GAP && timer == '0);
    // Frame end pops directly so back-to-back frames see a single idle/pop cycle.
    assign pop       = !empty && ((state == S_IDLE && !armed) || frame_end);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_level <= fifo_level + LVL_W'(push) - LVL_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            armed     <= 1'b0;
            tx_line   <= 1'b1;
            ps2_clk   <= 1'b1;
            busy      <= 1'b0;
            timer     <= '0;
            half      <= 1'b0;
            bit_idx   <= '0;
            data_q    <= '0;
            mode_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            div_m1_q  <= '0;
            gap_q     <= '0;
        end else if (pop) begin
            state     <= S_IDLE;
            armed     <= 1'b1;
            busy      <= 1'b0;
            tx_line   <= 1'b1;
            ps2_clk   <= 1'b1;
            data_q    <= head;
            mode_q    <= mode;
            par_en_q  <= mode || (parity_sel == 2'd1) || (parity_sel == 2'd2);
            par_bit_q <= par_odd ? ~^head : ^head;
            div_m1_q  <= (bit_div == '0) ? '0 : bit_div - DIV_W'(1);
            gap_q     <= gap;
        end else begin
            case (state)
                S_IDLE: begin
                    if (armed) begin
                        armed   <= 1'b0;
                        state   <= S_START;
                        busy    <= 1'b1;
                        tx_line <= 1'b0;
                        ps2_clk <= !mode_q;
                        timer   <= div_m1_q;
                        half    <= 1'b0;
                    end
                end
                S_GAP: begin
                    if (timer == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer - DIV_W'(1);
                    end
                end
                S_START, S_DATA, S_PAR, S_STOP: begin
                    if (timer != '0) begin
                        timer <= timer - DIV_W'(1);
                    end else if (!bit_end) begin
                        half    <= 1'b1;
                        ps2_clk <= 1'b1;
                        timer   <= div_m1_q;
                    end else begin
                        half    <= 1'b0;
                        timer   <= div_m1_q;
                        ps2_clk <= !mode_q;
                        case (state)
                            S_START: begin
                                state   <= S_DATA;
                                bit_idx <= '0;
                                tx_line <= data_q[0];
                            end
                            S_DATA: begin
                                if (bit_idx != 3'd7) begin
                                    bit_idx <= bit_idx + 3'd1;
                                    tx_line <= data_q[bit_idx + 3'd1];
                                end else if (par_en_q) begin
                                    state   <= S_PAR;
                                    tx_line <= par_bit_q;
                                end else begin
                                    state   <= S_STOP;
                                    tx_line <= 1'b1;
                                end
                            end
                            S_PAR: begin
                                state   <= S_STOP;
                                tx_line <= 1'b1;
                            end
                            S_STOP: begin
                                tx_line <= 1'b1;
                                ps2_clk <= 1'b1;
                                if (gap_q != '0) begin
                                    state <= S_GAP;
                                    timer <= gap_q - DIV_W'(1);
                                end else begin
                                    state <= S_IDLE;
                                    busy  <= 1'b0;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_frame_gen.sv
// tb/tb_serial_frame_gen.sv - randomized and directed bench for serial_frame_gen against a waveform-queue model
module tb_serial_frame_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic        mode;
    logic [15:0] bit_div;
    logic [1:0]  parity_sel;
    logic [15:0] gap;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        tx_line;
    logic        ps2_clk;
    logic        busy;
    logic [4:0]  fifo_level;

    int vectors     = 0;
    int miscompares = 0;

    serial_frame_gen #(.DIV_W(16), .FIFO_DEPTH(16), .LVL_W(5)) dut (
        .clk(clk), .reset(reset), .mode(mode), .bit_div(bit_div), .parity_sel(parity_sel),
        .gap(gap), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .tx_line(tx_line), .ps2_clk(ps2_clk), .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    // Model: queued bytes plus a per-cycle list of {tx_line, ps2_clk, busy} for the frame in flight.
    logic [7:0] fq[$];
    logic [2:0] wq[$];
    logic [2:0] model_s;
    logic       model_acc;
    logic [8:0] exp_vec = 9'b110_1_00000;
    wire  [8:0] obs = {tx_line, ps2_clk, busy, in_ready, fifo_level};

    task automatic build_frame(input logic [7:0] b);
        int   d;
        logic bits[$];
        d = (bit_div == 16'd0) ? 1 : int'(bit_div);
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
        if (mode || parity_sel == 2'd1) bits.push_back(~^b);
        else if (parity_sel == 2'd2) bits.push_back(^b);
        bits.push_back(1'b1);
        wq.push_back(3'b110);
        foreach (bits[i]) begin
            if (mode) begin
                repeat (d) wq.push_back({bits[i], 2'b01});
                repeat (d) wq.push_back({bits[i], 2'b11});
            end else begin
                repeat (d) wq.push_back({bits[i], 2'b11});
            end
        end
        repeat (int'(gap)) wq.push_back(3'b111);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            wq.delete();
            fq.delete();
            model_s = 3'b110;
        end else begin
            model_acc = in_valid && (fq.size() < 16);
            if (wq.size() == 0 && fq.size() != 0) build_frame(fq.pop_front());
            model_s = (wq.size() != 0) ? wq.pop_front() : 3'b110;
            if (model_acc) fq.push_back(in_data);
        end
        exp_vec = {model_s, fq.size() < 16, 5'(fq.size())};
    end

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        mode = 1'b0; bit_div = 16'd8; parity_sel = 2'd0; gap = 16'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if (obs !== 9'b110_1_00000) begin
            miscompares++; $display("FAIL reset_values got %b want %b", obs, 9'b110_1_00000);
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs !== exp_vec) begin
            miscompares++; $display("FAIL reset_idle got %b want %b", obs, exp_vec);
        end
    endtask

    task automatic test_uart_basic();
        logic       txs[$];
        int         busy_cnt = 0;
        logic [9:0] want = 10'b1010000010;
        mode = 1'b0; bit_div = 16'd8; parity_sel = 2'd0; gap = 16'd0;
        in_data = 8'h41; in_valid = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk); in_valid = 1'b0;
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++; $display("FAIL uart_wave c=%0d got %b want %b", c, obs, exp_vec);
            end
            if (busy) begin txs.push_back(tx_line); busy_cnt++; end
        end
        vectors++;
        if (busy_cnt !== 80) begin
            miscompares++; $display("FAIL uart_busy_len got %0d want 80", busy_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (txs[8*i+4] !== want[i]) begin
                miscompares++; $display("FAIL uart_bit%0d got %b want %b", i, txs[8*i+4], want[i]);
            end
        end
    endtask

    task automatic test_ps2();
        logic        falls[$];
        int          fall_t[$];
        logic        prev_pc = 1'b1;
        logic [10:0] want = 11'b11010000010;
        mode = 1'b1; bit_div = 16'd4; parity_sel = 2'd0; gap = 16'd0;
        in_data = 8'h41; in_valid = 1'b1;
        for (int c = 0; c < 110; c++) begin
            @(negedge clk); in_valid = 1'b0;
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++; $display("FAIL ps2_wave c=%0d got %b want %b", c, obs, exp_vec);
            end
            if (prev_pc && !ps2_clk) begin falls.push_back(tx_line); fall_t.push_back(c); end
            prev_pc = ps2_clk;
        end
        vectors++;
        if (falls.size() != 11) begin
            miscompares++; $display("FAIL ps2_fall_count got %0d want 11", falls.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                vectors++;
                if (falls[i] !== want[i]) begin
                    miscompares++; $display("FAIL ps2_bit%0d got %b want %b", i, falls[i], want[i]);
                end
                if (i > 0) begin
                    vectors++;
                    if (fall_t[i] - fall_t[i-1] != 8) begin
                        miscompares++;
                        $display("FAIL ps2_fall_spacing%0d got %0d want 8", i, fall_t[i] - fall_t[i-1]);
                    end
                end
            end
        end
    endtask

    task automatic test_parity();
        logic [1:0] sels[2] = '{2'd2, 2'd1};
        logic       pbits[2] = '{1'b1, 1'b0};
        for (int k = 0; k < 2; k++) begin
            logic txs[$];
            int   busy_cnt = 0;
            mode = 1'b0; bit_div = 16'd8; parity_sel = sels[k]; gap = 16'd0;
            in_data = 8'h07; in_valid = 1'b1;
            for (int c = 0; c < 110; c++) begin
                @(negedge clk); in_valid = 1'b0;
                vectors++;
                if (obs !== exp_vec) begin
                    miscompares++; $display("FAIL parity_wave k=%0d c=%0d got %b want %b", k, c, obs, exp_vec);
                end
                if (busy) begin txs.push_back(tx_line); busy_cnt++; end
            end
            vectors++;
            if (busy_cnt !== 88) begin
                miscompares++; $display("FAIL parity_len k=%0d got %0d want 88", k, busy_cnt);
            end
            vectors++;
            if (txs[76] !== pbits[k]) begin
                miscompares++; $display("FAIL parity_bit k=%0d got %b want %b", k, txs[76], pbits[k]);
            end
        end
    endtask

    task automatic test_fifo_full();
        int waited = 0;
        mode = 1'b0; bit_div = 16'd1000; parity_sel = 2'd0; gap = 16'd0;
        in_data = 8'hA5; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); in_valid = 1'b0;
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++; $display("FAIL full_start c=%0d got %b want %b", c, obs, exp_vec);
            end
        end
        for (int i = 0; i < 17; i++) begin
            in_data = 8'($urandom); in_valid = 1'b1;
            @(negedge clk);
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++; $display("FAIL full_fill i=%0d got %b want %b", i, obs, exp_vec);
            end
        end
        in_valid = 1'b0;
        vectors++;
        if (fifo_level !== 5'd16) begin
            miscompares++; $display("FAIL full_level got %0d want 16", fifo_level);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++; $display("FAIL full_ready got %b want 0", in_ready);
        end
        bit_div = 16'd2;
        while ((wq.size() != 0 || fq.size() != 0 || busy) && waited < 20000) begin
            @(negedge clk); waited++;
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++; $display("FAIL full_drain c=%0d got %b want %b", waited, obs, exp_vec);
            end
        end
        vectors++;
        if (waited >= 20000) begin
            miscompares++; $display("FAIL full_drain_timeout got %0d cycles want <20000", waited);
        end
    endtask

    task automatic test_gap();
        logic txs[$];
        int   idx = 0;
        int   run = 0;
        mode = 1'b0; bit_div = 16'd4; parity_sel = 2'd0; gap = 16'd20;
        in_data = 8'h00; in_valid = 1'b1;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            in_valid = (c == 0);
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++; $display("FAIL gap_wave c=%0d got %b want %b", c, obs, exp_vec);
            end
            txs.push_back(tx_line);
        end
        while (idx < txs.size() && txs[idx] !== 1'b0) idx++;
        while (idx < txs.size() && txs[idx] === 1'b0) idx++;
        while (idx < txs.size() && txs[idx] === 1'b1) begin run++; idx++; end
        // stop bit (4) + gap (20) + pop cycle (1)
        vectors++;
        if (run != 25) begin
            miscompares++; $display("FAIL gap_idle_run got %0d want 25", run);
        end
    endtask

    task automatic test_reset_mid();
        int   nfalls = 0;
        logic prev_pc = 1'b1;
        mode = 1'b1; bit_div = 16'd5; parity_sel = 2'd0; gap = 16'd0;
        in_valid = 1'b1; in_data = 8'($urandom);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            in_valid = (c < 2); in_data = 8'($urandom);
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++; $display("FAIL rmid_pre c=%0d got %b want %b", c, obs, exp_vec);
            end
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (obs !== 9'b110_1_00000) begin
            miscompares++; $display("FAIL rmid_after_reset got %b want %b", obs, 9'b110_1_00000);
        end
        in_data = 8'($urandom); in_valid = 1'b1;
        for (int c = 0; c < 130; c++) begin
            @(negedge clk); in_valid = 1'b0;
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++; $display("FAIL rmid_post c=%0d got %b want %b", c, obs, exp_vec);
            end
            if (prev_pc && !ps2_clk) nfalls++;
            prev_pc = ps2_clk;
        end
        vectors++;
        if (nfalls != 11) begin
            miscompares++; $display("FAIL rmid_fresh_frame falls got %0d want 11", nfalls);
        end
    endtask

    task automatic test_random();
        int waited = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++; $display("FAIL rand_wave c=%0d got %b want %b", c, obs, exp_vec);
            end
            in_valid = ($urandom_range(0, 3) == 0);
            in_data  = 8'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                mode       = 1'($urandom);
                bit_div    = 16'($urandom_range(0, 4));
                parity_sel = 2'($urandom);
                gap        = 16'($urandom_range(0, 6));
            end
        end
        in_valid = 1'b0;
        while ((wq.size() != 0 || fq.size() != 0 || busy) && waited < 5000) begin
            @(negedge clk); waited++;
            vectors++;
            if (obs !== exp_vec) begin
                miscompares++; $display("FAIL rand_drain c=%0d got %b want %b", waited, obs, exp_vec);
            end
        end
        vectors++;
        if (waited >= 5000) begin
            miscompares++; $display("FAIL rand_drain_timeout got %0d cycles want <5000", waited);
        end
    endtask

    initial begin
        test_reset();
        test_uart_basic();
        test_ps2();
        test_parity();
        test_fifo_full();
        test_gap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
